// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: opcode and FSM
// state encodings, default occupancies and an opcode classification helper.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath, signed or unsigned.
// Division by zero yields zeros; the controller never commits that result.
module md_arith (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [63:0] a_ext, b_ext;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uq, ur;

  always_comb begin
    a_ext  = signed_i ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    b_ext  = signed_i ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    prod_o = a_ext * b_ext;
  end

  // Sign-magnitude division avoids the -2^31 / -1 overflow trap and gives
  // truncation toward zero with the remainder following the dividend.
  always_comb begin
    neg_a = signed_i & a_i[31];
    neg_b = signed_i & b_i[31];
    mag_a = neg_a ? (32'd0 - a_i) : a_i;
    mag_b = neg_b ? (32'd0 - b_i) : b_i;
    if (mag_b == '0) begin
      uq = '0;
      ur = '0;
    end else begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quot_o = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem_o  = neg_a ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide unit controller: fixed-occupancy MUL/DIV sequencing,
// HI/LO architectural registers, MTHI/MTLO writes and the MD stall request.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic             sgn_q, done_q;

  logic [63:0] prod;
  logic [31:0] quot, rem;

  md_arith u_arith (
    .a_i      (a_q),
    .b_i      (b_q),
    .signed_i (sgn_q),
    .prod_o   (prod),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              OP_MULT, OP_MULTU: begin
                a_q     <= src_a;
                b_q     <= src_b;
                sgn_q   <= (md_op == OP_MULT);
                cnt_q   <= CNT_W'(MULT_CYC - 1);
                state_q <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                a_q     <= src_a;
                b_q     <= src_b;
                sgn_q   <= (md_op == OP_DIV);
                cnt_q   <= CNT_W'(DIV_CYC - 1);
                state_q <= ST_DIV;
              end
              OP_MTHI: hi_q <= src_a;
              OP_MTLO: lo_q <= src_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (cnt_q == '0) begin
            if (b_q != '0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign stall_md = d_is_md & (busy | (start & is_muldiv(md_op)));
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table, hand-written
// stall/reset/ignore-while-busy sequences, then random ops against a model.
module tb_md_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_md, done;
  logic [31:0] hi, lo;

  md_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo;

  int          r_busy, r_done_busy;
  logic        r_done_first, r_done_after, r_timeout;
  logic [31:0] r_hi, r_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic md_kind(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  // Reference: architectural result from plain 64-bit integer arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op; optionally inject a MTLO 0x55 start on busy cycle 'inj'.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
    model_apply(op, a, b);
    r_busy = 0; r_done_busy = 0; r_timeout = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      if (!busy) begin r_timeout = 1'b0; break; end
      r_busy++;
      if (done) r_done_busy++;
      if (r_busy == inj) begin start = 1'b1; md_op = 3'd6; src_a = 32'h55; end
    end
    r_done_first = done; r_hi = hi; r_lo = lo;
    @(negedge clk);
    r_done_after = done;
  endtask

  task automatic verify(input string tag, input logic [2:0] op, input int eb,
                        input logic [31:0] eh, input logic [31:0] el);
    check({tag, ".timeout"}, r_timeout, 0);
    check({tag, ".busy_cycles"}, r_busy, eb);
    check({tag, ".done_pulse"}, r_done_first, md_kind(op));
    check({tag, ".done_while_busy"}, r_done_busy, 0);
    check({tag, ".done_after"}, r_done_after, 0);
    check({tag, ".hi"}, r_hi, eh);
    check({tag, ".lo"}, r_lo, el);
  endtask

  initial begin
    int cnt;
    logic ok;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{3'd5, 32'h11,       32'h0,        0,  32'h11,       32'h0};
    vecs[1]  = '{3'd6, 32'h22,       32'h0,        0,  32'h11,       32'h22};
    vecs[2]  = '{3'd3, 32'd5,        32'd0,        DC, 32'h11,       32'h22};
    vecs[3]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        MC, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[4]  = '{3'd4, 32'd100,      32'd7,        DC, 32'd2,        32'd14};
    vecs[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0,        32'h80000000};
    vecs[7]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h1};
    vecs[8]  = '{3'd0, 32'd123,      32'd456,      0,  32'hFFFFFFFE, 32'h1};
    vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, DC, 32'h1,        32'hFFFFFFFD};
    vecs[10] = '{3'd7, 32'd9,        32'd9,        0,  32'h1,        32'hFFFFFFFD};
    vecs[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, DC, 32'h80000000, 32'h0};
    vecs[12] = '{3'd1, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h0};

    // Reset held with a competing MTHI start: reset must win.
    reset = 1'b1; start = 1'b1; md_op = 3'd5; src_a = 32'hDEAD; src_b = '0; d_is_md = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; md_op = 3'd0;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0);
      verify($sformatf("vec%0d", i), vecs[i].op, vecs[i].busy_cyc, vecs[i].hi, vecs[i].lo);
    end

    // Starts while busy are ignored, including on the commit cycle.
    run_op(3'd1, 32'd2, 32'd3, 2);
    verify("ignore_mid", 3'd1, MC, 32'd0, 32'd6);
    run_op(3'd4, 32'd50, 32'd5, DC);
    verify("ignore_last", 3'd4, DC, 32'd0, 32'd10);

    // Stall request across a MULT with d_is_md held high.
    @(negedge clk);
    d_is_md = 1'b0; start = 1'b1; md_op = 3'd1;
    #1 check("stall.no_d", stall_md, 0);
    d_is_md = 1'b1; md_op = 3'd5;
    #1 check("stall.mthi", stall_md, 0);
    md_op = 3'd1; src_a = 32'd4; src_b = 32'd5;
    #1 check("stall.start", stall_md, 1);
    @(posedge clk);
    #1 start = 1'b0; md_op = 3'd0;
    model_apply(3'd1, 32'd4, 32'd5);
    cnt = 0; ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (!stall_md) ok = 1'b0;
    end
    check("stall.busy_cycles", cnt, MC);
    check("stall.during_busy", ok, 1);
    check("stall.after", stall_md, 0);
    check("stall.lo", lo, 32'd20);
    d_is_md = 1'b0;

    // Reset on the third busy cycle of DIVU aborts without commit or done.
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; md_op = 3'd0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("abort.busy_before", cnt, 3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort.busy", busy, 0);
    check("abort.hi", hi, 0);
    check("abort.lo", lo, 0);
    check("abort.done", done, 0);
    @(negedge clk);
    check("abort.done_later", done, 0);
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'hFFFFFFFF;
        2, 3:    b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      verify($sformatf("rnd%0d", i), op, exp_busy(op), m_hi, m_lo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
